battery_charge_scheduler: RTL and testbench

Time-shares a single bench charger between battery A and battery B. Each cycle it registers both 4-bit charge levels and picks which battery gets the charger. It enforces break-before-make switching and minimum/maximum dwell times, and raises an empty-battery alarm. It sits beside the battery bench level/state-indicator logic and receives the same active-high 4-bit levels after board-polarity inversion at top level.

---
 rtl/battery_charge_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_battery_charge_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/battery_charge_scheduler.sv
// Two-battery charge scheduler: break-before-make charger switching with dwell limits and empty alarm.
// Optional macro BATT_SCHED_FAULT_EN adds a level-drop fault state that latches until reset.
module battery_charge_scheduler #(
  parameter logic [3:0]  FULL_LEVEL    = 4'd15,
  parameter logic [3:0]  EMPTY_LEVEL   = 4'd0,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MIN_DWELL     = 16,
  parameter int unsigned MAX_DWELL     = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] battA,
  input  logic [3:0] battB,
  output logic       charge_enA,
  output logic       charge_enB,
  output logic [2:0] state,
  output logic       alarm,
  output logic       done,
  output logic       fault
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETTLE   = 3'd1;
  localparam logic [2:0] ST_CHARGE_A = 3'd2;
  localparam logic [2:0] ST_CHARGE_B = 3'd3;
  localparam logic [2:0] ST_FAULT    = 3'd4;

  localparam int unsigned          SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0]  SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [15:0]          DWELL_MAX   = 16'(MAX_DWELL);
  localparam logic [15:0]          DWELL_MIN   = 16'(MIN_DWELL);

  logic [3:0]          lev_a_q, lev_a_d;
  logic [3:0]          lev_b_q, lev_b_d;
  logic [2:0]          state_q, state_d;
  logic                target_q, target_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [15:0]         dwell_q, dwell_d;
  logic                charge_en_a_q, charge_en_a_d;
  logic                charge_en_b_q, charge_en_b_d;
  logic                alarm_q, alarm_d;
  logic                done_q, done_d;

  logic       a_full, b_full;
  logic [3:0] cur_lev, oth_lev;
  logic       cur_full, oth_full;
  logic       rotate_ok;
  logic       empty_alarm;

  assign a_full   = (lev_a_q >= FULL_LEVEL);
  assign b_full   = (lev_b_q >= FULL_LEVEL);
  // "Current" is the battery on the charger; only meaningful in the charge states.
  assign cur_lev  = (state_q == ST_CHARGE_B) ? lev_b_q : lev_a_q;
  assign oth_lev  = (state_q == ST_CHARGE_B) ? lev_a_q : lev_b_q;
  assign cur_full = (cur_lev >= FULL_LEVEL);
  assign oth_full = (oth_lev >= FULL_LEVEL);
  assign rotate_ok = (dwell_q >= DWELL_MAX) && (dwell_q >= DWELL_MIN) && (oth_lev < cur_lev);
  assign empty_alarm = enable & ((lev_a_q <= EMPTY_LEVEL) | (lev_b_q <= EMPTY_LEVEL));

`ifdef BATT_SCHED_FAULT_EN
  logic [3:0] snap_q, snap_d;
  logic       fault_q, fault_d;
  logic       level_drop;

  assign level_drop = (snap_q > cur_lev) && ((snap_q - cur_lev) >= 4'd2);
`endif

  always_comb begin
    lev_a_d      = battA;
    lev_b_d      = battB;
    state_d      = state_q;
    target_d     = target_q;
    settle_cnt_d = settle_cnt_q;
    dwell_d      = dwell_q;
    done_d       = 1'b0;
`ifdef BATT_SCHED_FAULT_EN
    snap_d       = snap_q;
`endif

    case (state_q)
      ST_IDLE: begin
        settle_cnt_d = '0;
        if (enable && (!a_full || !b_full)) begin
          state_d = ST_SETTLE;
          // Lower not-full level wins; a tie goes to A.
          if (a_full)      target_d = 1'b1;
          else if (b_full) target_d = 1'b0;
          else             target_d = (lev_b_q < lev_a_q);
        end
      end

      ST_SETTLE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d = target_q ? ST_CHARGE_B : ST_CHARGE_A;
          dwell_d = '0;
`ifdef BATT_SCHED_FAULT_EN
          snap_d  = target_q ? lev_b_q : lev_a_q;
`endif
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
        end
      end

      ST_CHARGE_A, ST_CHARGE_B: begin
        if (dwell_q < DWELL_MAX) dwell_d = dwell_q + 16'd1;
`ifdef BATT_SCHED_FAULT_EN
        if (level_drop) begin
          state_d = ST_FAULT;
        end else
`endif
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (cur_full) begin
          if (!oth_full) begin
            state_d      = ST_SETTLE;
            target_d     = (state_q == ST_CHARGE_A);
            settle_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else if (rotate_ok) begin
          state_d      = ST_SETTLE;
          target_d     = (state_q == ST_CHARGE_A);
          settle_cnt_d = '0;
        end
      end

`ifdef BATT_SCHED_FAULT_EN
      ST_FAULT: state_d = ST_FAULT;
`else
      ST_FAULT: state_d = ST_IDLE;
`endif

      default: state_d = ST_IDLE;
    endcase

    charge_en_a_d = (state_d == ST_CHARGE_A);
    charge_en_b_d = (state_d == ST_CHARGE_B);
`ifdef BATT_SCHED_FAULT_EN
    fault_d = fault_q | (state_d == ST_FAULT);
    alarm_d = empty_alarm | fault_d;
`else
    alarm_d = empty_alarm;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lev_a_q       <= '0;
      lev_b_q       <= '0;
      state_q       <= ST_IDLE;
      target_q      <= 1'b0;
      settle_cnt_q  <= '0;
      dwell_q       <= '0;
      charge_en_a_q <= 1'b0;
      charge_en_b_q <= 1'b0;
      alarm_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      lev_a_q       <= lev_a_d;
      lev_b_q       <= lev_b_d;
      state_q       <= state_d;
      target_q      <= target_d;
      settle_cnt_q  <= settle_cnt_d;
      dwell_q       <= dwell_d;
      charge_en_a_q <= charge_en_a_d;
      charge_en_b_q <= charge_en_b_d;
      alarm_q       <= alarm_d;
      done_q        <= done_d;
    end
  end

`ifdef BATT_SCHED_FAULT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      snap_q  <= snap_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign charge_enA = charge_en_a_q;
  assign charge_enB = charge_en_b_q;
  assign state      = state_q;
  assign alarm      = alarm_q;
  assign done       = done_q;

endmodule

// File: tb/tb_battery_charge_scheduler.sv
// Directed bench for battery_charge_scheduler; expectations are hand-computed cycle counts.
module tb_battery_charge_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] batt_a;
  logic [3:0] batt_b;
  logic       charge_en_a;
  logic       charge_en_b;
  logic [2:0] state;
  logic       alarm;
  logic       done;
  logic       fault;

  int checks = 0;
  int errors = 0;

  battery_charge_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .battA      (batt_a),
    .battB      (batt_b),
    .charge_enA (charge_en_a),
    .charge_enB (charge_en_b),
    .state      (state),
    .alarm      (alarm),
    .done       (done),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; batt_a = 4'd3; batt_b = 4'd7;
    tick(2);
    rst = 1'b0;
    tick(1);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++;
    if ({charge_en_a, charge_en_b} !== 2'b00) begin errors++; $display("FAIL reset_enables got %b want 00", {charge_en_a, charge_en_b}); end
    checks++;
    if ({done, fault, alarm} !== 3'b000) begin errors++; $display("FAIL reset_flags got done/fault/alarm %b want 000", {done, fault, alarm}); end
  endtask

  task automatic test_settle_to_charge_a;
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      checks++;
      if (state !== 3'd1 || charge_en_a !== 1'b0 || charge_en_b !== 1'b0) begin
        errors++;
        $display("FAIL settle_a cycle %0d got state %0d en %b%b want state 1 en 00", k, state, charge_en_a, charge_en_b);
      end
    end
    tick(1);
    checks++;
    if (state !== 3'd2 || charge_en_a !== 1'b1 || charge_en_b !== 1'b0) begin
      errors++;
      $display("FAIL charge_a_start got state %0d en %b%b want state 2 en 10", state, charge_en_a, charge_en_b);
    end
  endtask

  task automatic test_full_handover;
    batt_a = 4'd15; batt_b = 4'd7;
    tick(1);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL handover_latency got %0d want 2", state); end
    for (int k = 0; k < 4; k++) begin
      tick(1);
      checks++;
      if (state !== 3'd1 || charge_en_a !== 1'b0 || charge_en_b !== 1'b0) begin
        errors++;
        $display("FAIL handover_settle cycle %0d got state %0d en %b%b want state 1 en 00", k, state, charge_en_a, charge_en_b);
      end
    end
    tick(1);
    checks++;
    if (state !== 3'd3 || charge_en_b !== 1'b1 || charge_en_a !== 1'b0) begin
      errors++;
      $display("FAIL charge_b_start got state %0d en %b%b want state 3 en 01", state, charge_en_a, charge_en_b);
    end
    batt_b = 4'd15;
    tick(1);
    checks++;
    if (state !== 3'd3 || done !== 1'b0) begin errors++; $display("FAIL both_full_latency got state %0d done %b want 3 0", state, done); end
    tick(1);
    checks++;
    if (state !== 3'd0 || done !== 1'b1 || charge_en_b !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got state %0d done %b enB %b want 0 1 0", state, done, charge_en_b);
    end
    tick(1);
    checks++;
    if (state !== 3'd0 || done !== 1'b0) begin errors++; $display("FAIL done_single got state %0d done %b want 0 0", state, done); end
  endtask

  task automatic test_rotation;
    batt_a = 4'd5; batt_b = 4'd2;
    tick(2);
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL rot_settle got %0d want 1", state); end
    tick(4);
    checks++;
    if (state !== 3'd3 || charge_en_b !== 1'b1) begin errors++; $display("FAIL rot_charge_b got state %0d enB %b want 3 1", state, charge_en_b); end
    batt_b = 4'd9;
    tick(256);
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL rot_before_max got %0d want 3", state); end
    tick(1);
    checks++;
    if (state !== 3'd1 || charge_en_b !== 1'b0 || charge_en_a !== 1'b0) begin
      errors++;
      $display("FAIL rot_at_max got state %0d en %b%b want 1 00", state, charge_en_a, charge_en_b);
    end
    tick(3);
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL rot_settle_len got %0d want 1", state); end
    tick(1);
    checks++;
    if (state !== 3'd2 || charge_en_a !== 1'b1) begin errors++; $display("FAIL rot_to_a got state %0d enA %b want 2 1", state, charge_en_a); end
  endtask

  task automatic test_no_rotation;
    batt_b = 4'd4;
    tick(256);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL norot_a_hold got %0d want 2", state); end
    tick(1);
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL norot_a_leave got %0d want 1", state); end
    tick(4);
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL norot_b_enter got %0d want 3", state); end
    tick(300);
    checks++;
    if (state !== 3'd3 || charge_en_b !== 1'b1 || charge_en_a !== 1'b0) begin
      errors++;
      $display("FAIL norot_b_hold got state %0d en %b%b want 3 01", state, charge_en_a, charge_en_b);
    end
  endtask

  task automatic test_reset_mid_charge;
    rst = 1'b1;
    tick(1);
    checks++;
    if (state !== 3'd0 || charge_en_b !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got state %0d enB %b done %b want 0 0 0", state, charge_en_b, done);
    end
  endtask

  task automatic test_alarm_and_enable_drop;
    enable = 1'b0; batt_a = 4'd9; batt_b = 4'd2;
    tick(1);
    rst = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(5);
    checks++;
    if (state !== 3'd3 || alarm !== 1'b0) begin errors++; $display("FAIL alarm_setup got state %0d alarm %b want 3 0", state, alarm); end
    batt_a = 4'd0;
    tick(1);
    checks++;
    if (alarm !== 1'b0) begin errors++; $display("FAIL alarm_early got %b want 0", alarm); end
    tick(1);
    checks++;
    if (alarm !== 1'b1 || state !== 3'd3) begin errors++; $display("FAIL alarm_on got alarm %b state %0d want 1 3", alarm, state); end
    enable = 1'b0;
    tick(1);
    checks++;
    if (charge_en_b !== 1'b0 || state !== 3'd0 || alarm !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL enable_drop got enB %b state %0d alarm %b done %b want 0 0 0 0", charge_en_b, state, alarm, done);
    end
  endtask

  task automatic test_fault;
    batt_a = 4'd8; batt_b = 4'd12; enable = 1'b1;
    tick(5);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL fault_setup got %0d want 2", state); end
    batt_a = 4'd6;
    tick(2);
`ifdef BATT_SCHED_FAULT_EN
    checks++;
    if (state !== 3'd4 || fault !== 1'b1 || alarm !== 1'b1 || charge_en_a !== 1'b0) begin
      errors++;
      $display("FAIL fault_enter got state %0d fault %b alarm %b enA %b want 4 1 1 0", state, fault, alarm, charge_en_a);
    end
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(2);
    checks++;
    if (state !== 3'd4 || fault !== 1'b1 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL fault_hold got state %0d fault %b alarm %b want 4 1 1", state, fault, alarm);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (state !== 3'd0 || fault !== 1'b0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear got state %0d fault %b alarm %b want 0 0 0", state, fault, alarm);
    end
`else
    checks++;
    if (state !== 3'd2 || fault !== 1'b0 || charge_en_a !== 1'b1) begin
      errors++;
      $display("FAIL nofault_keep got state %0d fault %b enA %b want 2 0 1", state, fault, charge_en_a);
    end
    enable = 1'b0;
    tick(1);
    checks++;
    if (state !== 3'd0 || fault !== 1'b0) begin errors++; $display("FAIL nofault_idle got state %0d fault %b want 0 0", state, fault); end
`endif
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; batt_a = '0; batt_b = '0;
    test_reset;
    test_settle_to_charge_a;
    test_full_handover;
    test_rotation;
    test_no_rotation;
    test_reset_mid_charge;
    test_alarm_and_enable_drop;
    test_fault;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
